// File: rtl/mesh_fabric_buffered.sv
// mesh_fabric_buffered: 2D mesh with one FIFO per directed neighbour link; define MESH_BYPASS_EN for empty-FIFO cut-through
package satswarmv2_pkg;
  typedef enum logic [1:0] {MSG_DATA, MSG_REQ, MSG_RESP, MSG_STATUS} msg_type_t;
  typedef struct packed {
    msg_type_t   msg_type;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [31:0] payload;
  } noc_packet_t;
endpackage

module mesh_fabric_buffered
  import satswarmv2_pkg::*;
#(
  parameter int GRID_X = 2,
  parameter int GRID_Y = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  noc_packet_t      core_tx       [GRID_Y][GRID_X][4],
  input  logic             core_tx_valid [GRID_Y][GRID_X][4],
  output logic             core_tx_ready [GRID_Y][GRID_X][4],
  output noc_packet_t      core_rx       [GRID_Y][GRID_X][4],
  output logic             core_rx_valid [GRID_Y][GRID_X][4],
  input  logic             core_rx_ready [GRID_Y][GRID_X][4],
  output logic [LVL_W-1:0] link_level    [GRID_Y][GRID_X][4]
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam noc_packet_t EDGE_PKT = '{MSG_STATUS, 8'h0, 8'h0, 32'h0};
  logic link_rdy [GRID_Y][GRID_X][4];
  for (genvar y = 0; y < GRID_Y; y++) begin : g_y
    for (genvar x = 0; x < GRID_X; x++) begin : g_x
      for (genvar p = 0; p < 4; p++) begin : g_p
        // the neighbour port is both this rx port's source and this tx port's sink
        localparam int NY = p == 3 ? y + 1 : p == 2 ? y - 1 : y;
        localparam int NX = p == 1 ? x - 1 : p == 0 ? x + 1 : x;
        localparam int NP = p == 3 ? 2 : p == 2 ? 3 : p == 1 ? 0 : 1;
        localparam bit HAS = NY >= 0 && NY < GRID_Y && NX >= 0 && NX < GRID_X;
        if (HAS) begin : g_link
          noc_packet_t mem [FIFO_DEPTH];
          noc_packet_t tx;
          logic [AW-1:0] wp, rp;
          logic [LVL_W-1:0] cnt;
          logic tx_v, rx_r, empty, byp, push, pop;
          assign tx = core_tx[NY][NX][NP];
          assign tx_v = core_tx_valid[NY][NX][NP];
          assign rx_r = core_rx_ready[y][x][p];
          assign empty = cnt == '0;
`ifdef MESH_BYPASS_EN
          assign byp = rst_n && empty && rx_r && tx_v;
`else
          assign byp = 1'b0;
`endif
          assign link_rdy[y][x][p] = rst_n && cnt < LVL_W'(FIFO_DEPTH);
          assign push = tx_v && link_rdy[y][x][p] && !byp;
          assign pop = rst_n && !empty && rx_r;
          assign core_rx_valid[y][x][p] = rst_n && (!empty || byp);
          assign core_rx[y][x][p] = !rst_n ? '0 : byp ? tx : !empty ? mem[rp] : '0;
          assign link_level[y][x][p] = rst_n ? cnt : '0;
          always_ff @(posedge clk) begin
            if (!rst_n) begin
              wp <= '0;
              rp <= '0;
              cnt <= '0;
            end else begin
              if (push) wp <= wp + AW'(1);
              if (pop) rp <= rp + AW'(1);
              cnt <= cnt + LVL_W'(push) - LVL_W'(pop);
            end
          end
          always_ff @(posedge clk) begin
            if (push) mem[wp] <= tx;
          end
          assign core_tx_ready[y][x][p] = link_rdy[NY][NX][NP];
        end else begin : g_edge
          assign link_rdy[y][x][p] = 1'b0;
          assign core_rx_valid[y][x][p] = 1'b0;
          assign core_rx[y][x][p] = EDGE_PKT;
          assign link_level[y][x][p] = '0;
          assign core_tx_ready[y][x][p] = 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mesh_fabric_buffered.sv
// tb_mesh_fabric_buffered: queue-model checks plus directed reset, hop, fill, stream, edge and mid-reset sequences
module tb_mesh_fabric_buffered;
  import satswarmv2_pkg::*;
  localparam int GX = 2;
  localparam int GY = 2;
  localparam int D = 4;
  localparam int LW = $clog2(D + 1);
`ifdef MESH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam noc_packet_t EDGE = '{MSG_STATUS, 8'h0, 8'h0, 32'h0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  noc_packet_t core_tx [GY][GX][4];
  logic core_tx_valid [GY][GX][4];
  logic core_tx_ready [GY][GX][4];
  noc_packet_t core_rx [GY][GX][4];
  logic core_rx_valid [GY][GX][4];
  logic core_rx_ready [GY][GX][4];
  logic [LW-1:0] link_level [GY][GX][4];
  mesh_fabric_buffered #(.GRID_X(GX), .GRID_Y(GY), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_tx(core_tx), .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_rx(core_rx), .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .link_level(link_level)
  );
  always #5 clk = ~clk;
  typedef struct { int y; int x; int p; logic rdy; } vec_t;
  vec_t vt [16];
  noc_packet_t q [GY][GX][4][$];
  logic rdy_s [GY][GX][4];
  int got[$];
  int my, mx, mp;
  int n_chk = 0;
  int n_fail = 0;
  function automatic bit nb(input int y, input int x, input int p, output int ny, output int nx, output int np);
    ny = p == 3 ? y + 1 : p == 2 ? y - 1 : y;
    nx = p == 1 ? x - 1 : p == 0 ? x + 1 : x;
    np = p == 3 ? 2 : p == 2 ? 3 : p == 1 ? 0 : 1;
    return ny >= 0 && ny < GY && nx >= 0 && nx < GX;
  endfunction
  function automatic noc_packet_t pkt(input int v);
    noc_packet_t r;
    r = '0;
    r.msg_type = MSG_DATA;
    r.payload = 32'(v);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic sample();
    @(negedge clk);
    for (int y = 0; y < GY; y++)
      for (int x = 0; x < GX; x++)
        for (int p = 0; p < 4; p++) begin
          int ny, nx, np, sz, lvl;
          bit byp, ev, er;
          noc_packet_t erx;
          string id;
          id = $sformatf("[%0d][%0d][%0d]", y, x, p);
          rdy_s[y][x][p] = core_tx_ready[y][x][p];
          er = 1'b0;
          ev = 1'b0;
          erx = EDGE;
          lvl = 0;
          if (nb(y, x, p, ny, nx, np)) begin
            er = rst_n && q[ny][nx][np].size() < D;
            sz = q[y][x][p].size();
            byp = BYP && rst_n && sz == 0 && core_rx_ready[y][x][p] && core_tx_valid[ny][nx][np];
            ev = rst_n && (sz != 0 || byp);
            if (!rst_n) erx = '0;
            else if (byp) erx = core_tx[ny][nx][np];
            else if (sz != 0) erx = q[y][x][p][0];
            else erx = '0;
            lvl = rst_n ? sz : 0;
          end
          chk({"tx_ready", id}, 64'(core_tx_ready[y][x][p]), 64'(er));
          chk({"rx_valid", id}, 64'(core_rx_valid[y][x][p]), 64'(ev));
          chk({"rx", id}, 64'(core_rx[y][x][p]), 64'(erx));
          chk({"level", id}, 64'(link_level[y][x][p]), 64'(lvl));
          if (core_rx_valid[y][x][p] && core_rx_ready[y][x][p] && y == my && x == mx && p == mp)
            got.push_back(int'(core_rx[y][x][p].payload));
        end
  endtask
  task automatic tick();
    @(posedge clk);
    for (int y = 0; y < GY; y++)
      for (int x = 0; x < GX; x++)
        for (int p = 0; p < 4; p++) begin
          int ny, nx, np, sz;
          bit byp, push, pop;
          if (nb(y, x, p, ny, nx, np)) begin
            sz = q[y][x][p].size();
            byp = BYP && sz == 0 && core_rx_ready[y][x][p] && core_tx_valid[ny][nx][np];
            pop = sz != 0 && core_rx_ready[y][x][p];
            push = core_tx_valid[ny][nx][np] && sz < D && !byp;
            if (!rst_n) q[y][x][p].delete();
            else begin
              if (pop) void'(q[y][x][p].pop_front());
              if (push) q[y][x][p].push_back(core_tx[ny][nx][np]);
            end
          end
        end
    #1;
  endtask
  task automatic cyc();
    sample();
    tick();
  endtask
  task automatic clr();
    for (int y = 0; y < GY; y++)
      for (int x = 0; x < GX; x++)
        for (int p = 0; p < 4; p++) begin
          core_tx_valid[y][x][p] = 1'b0;
          core_rx_ready[y][x][p] = 1'b1;
          core_tx[y][x][p] = pkt(0);
        end
  endtask
  task automatic send(input int y, input int x, input int p, input int v);
    core_tx_valid[y][x][p] = 1'b1;
    core_tx[y][x][p] = pkt(v);
    for (int i = 0; i < 20; i++) begin
      sample();
      tick();
      if (rdy_s[y][x][p]) begin
        core_tx_valid[y][x][p] = 1'b0;
        return;
      end
    end
    core_tx_valid[y][x][p] = 1'b0;
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout[%0d][%0d][%0d]: payload %0d not accepted in 20 cycles", y, x, p, v);
  endtask
  task automatic tbl_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      string id;
      id = $sformatf("%s[%0d][%0d][%0d]", tag, vt[i].y, vt[i].x, vt[i].p);
      chk({id, "_tx_ready"}, 64'(core_tx_ready[vt[i].y][vt[i].x][vt[i].p]), 64'(vt[i].rdy));
      chk({id, "_rx_valid"}, 64'(core_rx_valid[vt[i].y][vt[i].x][vt[i].p]), 64'(0));
      chk({id, "_level"}, 64'(link_level[vt[i].y][vt[i].x][vt[i].p]), 64'(0));
      if (!vt[i].rdy) chk({id, "_edge_rx"}, 64'(core_rx[vt[i].y][vt[i].x][vt[i].p]), 64'(EDGE));
    end
  endtask
  task automatic chk_seq(input string nm, input int n);
    int bad;
    bad = 0;
    chk({nm, "_count"}, 64'(got.size()), 64'(n));
    foreach (got[i]) if (got[i] != i + 1) bad++;
    chk({nm, "_order"}, 64'(bad), 64'(0));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int nxt, cycles;
    vt = '{'{0, 0, 3, 1'b1}, '{0, 0, 2, 1'b0}, '{0, 0, 1, 1'b0}, '{0, 0, 0, 1'b1},
           '{0, 1, 3, 1'b1}, '{0, 1, 2, 1'b0}, '{0, 1, 1, 1'b1}, '{0, 1, 0, 1'b0},
           '{1, 0, 3, 1'b0}, '{1, 0, 2, 1'b1}, '{1, 0, 1, 1'b0}, '{1, 0, 0, 1'b1},
           '{1, 1, 3, 1'b0}, '{1, 1, 2, 1'b1}, '{1, 1, 1, 1'b1}, '{1, 1, 0, 1'b0}};
    my = -1; mx = -1; mp = -1;
    clr();
    for (int i = 0; i < 16; i++) core_tx_valid[vt[i].y][vt[i].x][vt[i].p] = 1'b1;
    repeat (3) cyc();
    clr();
    rst_n = 1'b1;
    #1;
    tbl_check("reset");
    for (int i = 0; i < 16; i++) core_tx_valid[vt[i].y][vt[i].x][vt[i].p] = !vt[i].rdy;
    repeat (2) cyc();
    tbl_check("edge");
    clr();
    my = 0; mx = 1; mp = 1;
    got.delete();
    core_tx[0][0][0] = pkt(8'hA5);
    core_tx_valid[0][0][0] = 1'b1;
`ifdef MESH_BYPASS_EN
    sample();
    chk("hop_same_cycle_valid", 64'(core_rx_valid[0][1][1]), 64'(1));
    chk("hop_same_cycle_payload", 64'(core_rx[0][1][1].payload), 64'(8'hA5));
    tick();
`else
    sample();
    chk("hop_no_early_valid", 64'(core_rx_valid[0][1][1]), 64'(0));
    tick();
    chk("hop_valid", 64'(core_rx_valid[0][1][1]), 64'(1));
    chk("hop_payload", 64'(core_rx[0][1][1].payload), 64'(8'hA5));
`endif
    core_tx_valid[0][0][0] = 1'b0;
    repeat (2) cyc();
    chk("hop_delivered_once", 64'(got.size()), 64'(1));
    clr();
    my = 1; mx = 0; mp = 2;
    got.delete();
    core_rx_ready[1][0][2] = 1'b0;
    for (int k = 1; k <= 4; k++) send(0, 0, 3, k);
    chk("fill_level", 64'(link_level[1][0][2]), 64'(4));
    chk("fill_tx_ready", 64'(core_tx_ready[0][0][3]), 64'(0));
    core_tx_valid[0][0][3] = 1'b1;
    core_tx[0][0][3] = pkt(5);
    repeat (3) cyc();
    chk("fill_stall_level", 64'(link_level[1][0][2]), 64'(4));
    core_rx_ready[1][0][2] = 1'b1;
    send(0, 0, 3, 5);
    send(0, 0, 3, 6);
    repeat (8) cyc();
    chk_seq("fill", 6);
    clr();
    my = 1; mx = 0; mp = 0;
    got.delete();
    core_rx_ready[1][0][0] = 1'b0;
    for (int k = 1; k <= 4; k++) send(1, 1, 1, k);
    chk("stream_full_level", 64'(link_level[1][0][0]), 64'(4));
    core_rx_ready[1][0][0] = 1'b1;
    nxt = 5;
    cycles = 0;
    while (nxt <= 104 && cycles < 200) begin
      core_tx_valid[1][1][1] = 1'b1;
      core_tx[1][1][1] = pkt(nxt);
      sample();
      tick();
      cycles++;
      if (rdy_s[1][1][1]) nxt++;
    end
    core_tx_valid[1][1][1] = 1'b0;
    chk("stream_cycles", 64'(cycles), 64'(101));
    repeat (8) cyc();
    chk_seq("stream", 104);
    clr();
    my = 0; mx = 1; mp = 1;
    got.delete();
    core_rx_ready[0][1][1] = 1'b0;
    for (int k = 7; k <= 9; k++) send(0, 0, 0, k);
    chk("midrst_level_before", 64'(link_level[0][1][1]), 64'(3));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_level_after", 64'(link_level[0][1][1]), 64'(0));
    chk("midrst_valid_after", 64'(core_rx_valid[0][1][1]), 64'(0));
    core_rx_ready[0][1][1] = 1'b1;
    repeat (5) cyc();
    chk("midrst_no_delivery", 64'(got.size()), 64'(0));
    my = -1;
    for (int c = 0; c < 500; c++) begin
      rst_n = $urandom_range(0, 99) != 0;
      for (int y = 0; y < GY; y++)
        for (int x = 0; x < GX; x++)
          for (int p = 0; p < 4; p++) begin
            core_tx_valid[y][x][p] = $urandom_range(0, 1) == 1;
            core_rx_ready[y][x][p] = $urandom_range(0, 3) != 0;
            core_tx[y][x][p].msg_type = msg_type_t'($urandom_range(0, 3));
            core_tx[y][x][p].src = 8'($urandom);
            core_tx[y][x][p].dst = 8'($urandom);
            core_tx[y][x][p].payload = $urandom;
          end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
